fifo_read_packer: RTL and testbench

FIFO_READ_PACKER -- requirements
Module: fifo_read_packer

---
 rtl/fifo_pkg.sv | 18 +
 rtl/pack_accumulator.sv | 61 ++++++
 rtl/fifo_read_packer.sv | 142 ++++++++++++++
 tb/tb_fifo_read_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO read packer.
// Used by fifo_read_packer and pack_accumulator.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK       = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Lane counter must reach PACK itself (a full word parked in HOLD).
  function automatic int lane_cnt_w(input int pack);
    return $clog2(pack) + 1;
  endfunction

endpackage

// File: rtl/pack_accumulator.sv
// Lane register for fifo_read_packer: fills lanes 0..PACK-1 in order.
// Cleared to zero on clr, so the unused lanes of a partial word read as zero.
module pack_accumulator
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK       = DEF_PACK
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cap,
  input  logic                         clr,
  input  logic [DATA_WIDTH-1:0]        cap_data,
  output logic [$clog2(PACK):0]        lanes,
  output logic [DATA_WIDTH*PACK-1:0]   word,
  output logic [DATA_WIDTH*PACK-1:0]   word_cap
);

  localparam int CW = lane_cnt_w(PACK);
  localparam int WW = DATA_WIDTH * PACK;

  logic [CW-1:0] lanes_q, lanes_d;
  logic [WW-1:0] word_q, word_d;

  // Current word with the incoming entry already placed in the next free lane.
  always_comb begin
    word_cap = word_q;
    for (int i = 0; i < PACK; i++) begin
      if (lanes_q == CW'(i)) begin
        word_cap[i*DATA_WIDTH +: DATA_WIDTH] = cap_data;
      end
    end
  end

  // Clear wins over capture: a completing capture is consumed via word_cap.
  always_comb begin
    lanes_d = lanes_q;
    word_d  = word_q;
    if (clr) begin
      lanes_d = '0;
      word_d  = '0;
    end else if (cap) begin
      lanes_d = lanes_q + CW'(1);
      word_d  = word_cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      word_q  <= '0;
    end else begin
      lanes_q <= lanes_d;
      word_q  <= word_d;
    end
  end

  assign lanes = lanes_q;
  assign word  = word_q;

endmodule

// File: rtl/fifo_read_packer.sv
// Reads a 1-cycle-latency synchronous FIFO and packs PACK entries per output word.
// Optional m_parity output when FIFO_READ_PACKER_PARITY_EN is defined.
//
// state | meaning
// FILL  | accumulating entries; output register may or may not be occupied
// HOLD  | accumulator full, output register occupied; reads stopped
module fifo_read_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK       = DEF_PACK
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_data,
  output logic                         fifo_r_en,
  input  logic                         flush,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH*PACK-1:0]   m_data,
  output logic [$clog2(PACK):0]        m_count
`ifdef FIFO_READ_PACKER_PARITY_EN
  ,
  output logic                         m_parity
`endif
);

  localparam int CW = lane_cnt_w(PACK);
  localparam int WW = DATA_WIDTH * PACK;
  localparam logic [CW:0]   PACK_SUM  = (CW+1)'(PACK);
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(PACK);

  pack_state_e   state_q, state_d;
  logic          rd_pending_q, rd_pending_d;
  logic          m_valid_q, m_valid_d;
  logic [WW-1:0] m_data_q, m_data_d;
  logic [CW-1:0] m_count_q, m_count_d;

  logic [CW-1:0] lanes;
  logic [WW-1:0] acc_word, acc_word_cap;
  logic [CW:0]   lanes_sum;
  logic          out_free, rd_en, word_done, hold_fire, flush_fire;
  logic          acc_cap, acc_clr;

  pack_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK       (PACK)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (acc_cap),
    .clr      (acc_clr),
    .cap_data (fifo_data),
    .lanes    (lanes),
    .word     (acc_word),
    .word_cap (acc_word_cap)
  );

  always_comb begin
    out_free  = !m_valid_q || m_ready;
    lanes_sum = {1'b0, lanes} + {{CW{1'b0}}, rd_pending_q};
    // Last lane may be requested only if the completing word can leave on the same edge.
    rd_en = !fifo_empty && (state_q == FILL) && !(flush && (lanes != '0)) &&
            ((lanes_sum < PACK_SUM) ||
             ((lanes_sum == PACK_SUM) && rd_pending_q && out_free));
    word_done  = rd_pending_q && (lanes == LAST_LANE);
    hold_fire  = (state_q == HOLD) && out_free;
    flush_fire = (state_q == FILL) && flush && (lanes != '0) && !rd_pending_q && out_free;
  end

  always_comb begin
    state_d      = state_q;
    rd_pending_d = rd_en;
    m_valid_d    = m_valid_q && !m_ready;
    m_data_d     = m_data_q;
    m_count_d    = m_count_q;
    acc_cap      = rd_pending_q;
    acc_clr      = 1'b0;
    if (word_done) begin
      if (out_free) begin
        m_valid_d = 1'b1;
        m_data_d  = acc_word_cap;
        m_count_d = FULL_CNT;
        acc_clr   = 1'b1;
      end else begin
        state_d = HOLD;
      end
    end else if (hold_fire) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_word;
      m_count_d = FULL_CNT;
      acc_clr   = 1'b1;
      state_d   = FILL;
    end else if (flush_fire) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_word;
      m_count_d = lanes;
      acc_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      rd_pending_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_count_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_count_q    <= m_count_d;
    end
  end

  // Reset gates the request directly so no read escapes while rst_n is low.
  assign fifo_r_en = rd_en && rst_n;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_count   = m_count_q;

`ifdef FIFO_READ_PACKER_PARITY_EN
  logic m_parity_q, m_parity_d;

  assign m_parity_d = ^m_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_parity_q <= 1'b0;
    end else begin
      m_parity_q <= m_parity_d;
    end
  end

  assign m_parity = m_parity_q;
`endif

endmodule

// File: tb/tb_fifo_read_packer.sv
// Scoreboard bench for fifo_read_packer: FIFO model, reference packing model, output monitor.
module tb_fifo_read_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int CW = 3;
  localparam int WW = DW * PK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_r_en;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [WW-1:0] m_data;
  logic [CW-1:0] m_count;
`ifdef FIFO_READ_PACKER_PARITY_EN
  logic          m_parity;
`endif

  fifo_read_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_count    (m_count)
`ifdef FIFO_READ_PACKER_PARITY_EN
    ,
    .m_parity   (m_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] data;
    logic [CW-1:0] count;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] push_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] model_lanes[$];
  int            checks = 0;
  int            errors = 0;

  // Upstream synchronous FIFO: writes land at the edge, read data is registered,
  // and the data bus carries junk whenever no read was made.
  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty) fifo_data <= fifo_q.pop_front();
    else                          fifo_data <= DW'($urandom);
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: entries are grouped in write order, PK per word, lane 0 first.
  task automatic push_entry(input logic [DW-1:0] v);
    logic [WW-1:0] w;
    push_q.push_back(v);
    model_lanes.push_back(v);
    if (model_lanes.size() == PK) begin
      w = '0;
      for (int i = 0; i < PK; i++) w[i*DW +: DW] = model_lanes[i];
      exp_q.push_back('{w, CW'(PK)});
      model_lanes.delete();
    end
  endtask

  task automatic do_flush();
    logic [WW-1:0] w;
    if (model_lanes.size() > 0) begin
      w = '0;
      for (int i = 0; i < model_lanes.size(); i++) w[i*DW +: DW] = model_lanes[i];
      exp_q.push_back('{w, CW'(model_lanes.size())});
      model_lanes.delete();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (!(fifo_empty && push_q.size() == 0 && !fifo_r_en) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= 1000), 32'd0);
    repeat (3) step();
  endtask

  task automatic wait_delivered(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !m_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_deliver_timeout"}, 32'(n >= 3000), 32'd0);
    step();
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stability under backpressure.
  logic          hold_prev = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic [CW-1:0] prev_count = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!(m_valid && m_data == prev_data && m_count == prev_count)) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b %h/%0d, expected v=1 %h/%0d",
                   m_valid, m_data, m_count, prev_data, prev_count);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h/%0d, expected no word", m_data, m_count);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.data || m_count !== e.count) begin
            errors++;
            $display("FAIL word: got %h/%0d, expected %h/%0d", m_data, m_count, e.data, e.count);
          end
`ifdef FIFO_READ_PACKER_PARITY_EN
          checks++;
          if (m_parity !== ^e.data) begin
            errors++;
            $display("FAIL parity: got %0b, expected %0b for %h", m_parity, ^e.data, e.data);
          end
`endif
        end
      end
      hold_prev  = m_valid && !m_ready;
      prev_data  = m_data;
      prev_count = m_count;
    end
  end

  initial begin
    int n;
    int cyc;
    int run;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_count", 32'(m_count), 32'd0);
    check("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
    step();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    step();

    // Preloaded 11..44: word valid 5 edges after the first read request
    push_entry(8'h11); push_entry(8'h22); push_entry(8'h33); push_entry(8'h44);
    n = 0;
    while (!fifo_r_en && n < 50) begin @(negedge clk); n++; end
    check("first_rd_en", 32'(fifo_r_en), 32'd1);
    cyc = 0;
    while (!m_valid && cyc < 50) begin @(negedge clk); cyc++; end
    check("latency", 32'(cyc), 32'd5);
    wait_delivered("lat");

    // 8 entries back to back: reads issued every cycle across the word boundary
    for (int i = 1; i <= 8; i++) push_entry(DW'(i));
    n = 0;
    while (!fifo_r_en && n < 50) begin @(negedge clk); n++; end
    run = 0;
    while (fifo_r_en && run < 20) begin run++; @(negedge clk); end
    check("rd_en_run", 32'(run), 32'd8);
    wait_delivered("thru");

    // Backpressure: one word out, one parked, reads stopped, rest left in FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_entry(DW'(8'h21 + i));
    repeat (20) step();
    @(negedge clk);
    check("hold_rd_en", 32'(fifo_r_en), 32'd0);
    check("hold_fifo_left", 32'(fifo_q.size()), 32'd4);
    check("hold_m_valid", 32'(m_valid), 32'd1);
    check("hold_m_data", m_data, 32'h24232221);
    check("hold_m_count", 32'(m_count), 32'd4);
    step();
    m_ready = 1'b1;
    wait_delivered("hold");

    // Partial word flush, then a flush with nothing accumulated
    push_entry(8'hAA); push_entry(8'hBB);
    wait_drained("flush");
    do_flush();
    wait_delivered("flush");
    do_flush();
    repeat (5) step();

    // Parity words 0x00000007 and 0x00000003
    push_entry(8'h07); push_entry(8'h00); push_entry(8'h00); push_entry(8'h00);
    push_entry(8'h03); push_entry(8'h00); push_entry(8'h00); push_entry(8'h00);
    wait_delivered("parity");

    // Reset mid-word discards the partial word
    push_entry(8'h55); push_entry(8'h66); push_entry(8'h77);
    wait_drained("rst");
    rst_n = 1'b0;
    model_lanes.delete();
    @(negedge clk);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_data", m_data, 32'd0);
    check("midrst_m_count", 32'(m_count), 32'd0);
    check("midrst_fifo_r_en", 32'(fifo_r_en), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    push_entry(8'h01); push_entry(8'h02); push_entry(8'h03); push_entry(8'h04);
    wait_delivered("rst");

    // Random traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      step();
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) push_entry(DW'($urandom));
    end
    while (model_lanes.size() != 0) push_entry(DW'($urandom));
    step();
    m_ready = 1'b1;
    wait_delivered("rand");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
